// File: rtl/cskip_pkg.sv
// Shared definitions for the block-serial carry-skip subtractor: default
// sizes, the control state encoding and the counter width helpers.
package cskip_pkg;

   localparam int CSKIP_WIDTH = 16;
   localparam int CSKIP_BLOCK = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Width able to hold the values 0..nblk (the skip counter).
   function automatic int skip_count_width(input int nblk);
      return (nblk < 1) ? 1 : $clog2(nblk + 1);
   endfunction

   // Width of the slice index; kept at least one bit for the single-slice case.
   function automatic int index_width(input int nblk);
      return (nblk <= 1) ? 1 : $clog2(nblk);
   endfunction

endpackage

// File: rtl/cskip_slice_sub.sv
// One carry-skip slice: ripple chain over BLOCK bits, a propagate AND and a
// 2:1 mux that lets the incoming carry bypass the ripple when every bit propagates.
module cskip_slice_sub #(
   parameter int BLOCK = 4
) (
   input  logic [BLOCK-1:0] a,
   input  logic [BLOCK-1:0] b_inv,
   input  logic             cin,
   output logic [BLOCK-1:0] sum,
   output logic             cout_skip,
   output logic             p
);

   logic [BLOCK:0]   carry;
   logic [BLOCK-1:0] prop;

   assign carry[0] = cin;

   for (genvar gi = 0; gi < BLOCK; gi++) begin : g_ripple
      assign prop[gi]      = a[gi] ^ b_inv[gi];
      assign sum[gi]       = prop[gi] ^ carry[gi];
      assign carry[gi+1]   = (a[gi] & b_inv[gi]) | (prop[gi] & carry[gi]);
   end

   assign p = &prop;
   // When all bits propagate the ripple output equals cin anyway; the mux only shortens the path.
   assign cout_skip = p ? cin : carry[BLOCK];

endmodule

// File: rtl/cskip_sub_serial.sv
// Block-serial subtractor: A - B computed one carry-skip slice per clock,
// with valid/ready on both sides and a count of slices that took the skip path.
module cskip_sub_serial
   import cskip_pkg::*;
#(
   parameter int WIDTH = CSKIP_WIDTH,
   parameter int BLOCK = CSKIP_BLOCK
) (
   input  logic                                          i_clk,
   input  logic                                          i_rst,
   input  logic                                          i_valid,
   output logic                                          o_ready,
   input  logic [WIDTH-1:0]                              i_minuend,
   input  logic [WIDTH-1:0]                              i_subtrahend,
   output logic                                          o_valid,
   input  logic                                          i_ready,
   output logic [WIDTH-1:0]                              o_result,
   output logic                                          o_borrow,
   output logic                                          o_overflow,
   output logic [skip_count_width(WIDTH/BLOCK)-1:0]      o_skip_count
);

   localparam int NBLK = WIDTH / BLOCK;
   localparam int CW   = skip_count_width(NBLK);
   localparam int KW   = index_width(NBLK);

   state_t state_reg, state_next;

   logic [WIDTH-1:0] a_reg;
   logic [WIDTH-1:0] b_inv_reg;
   logic [WIDTH-1:0] result_reg;
   logic             a_msb_reg;
   logic             b_msb_reg;
   logic             carry_reg;
   logic [KW-1:0]    k_reg;
   logic [CW-1:0]    skip_reg;
   logic             borrow_reg;
   logic             overflow_reg;

   logic [BLOCK-1:0] slice_sum;
   logic             slice_cout;
   logic             slice_p;
   logic             last_slice;

   assign last_slice = (k_reg == KW'(NBLK - 1));

   cskip_slice_sub #(
      .BLOCK (BLOCK)
   ) u_slice (
      .a         (a_reg[k_reg*BLOCK +: BLOCK]),
      .b_inv     (b_inv_reg[k_reg*BLOCK +: BLOCK]),
      .cin       (carry_reg),
      .sum       (slice_sum),
      .cout_skip (slice_cout),
      .p         (slice_p)
   );

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (i_valid)    state_next = RUN;
         RUN:     if (last_slice) state_next = DONE;
         DONE:    if (i_ready)    state_next = IDLE;
         default:                 state_next = IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         a_reg        <= '0;
         b_inv_reg    <= '0;
         result_reg   <= '0;
         a_msb_reg    <= 1'b0;
         b_msb_reg    <= 1'b0;
         carry_reg    <= 1'b0;
         k_reg        <= '0;
         skip_reg     <= '0;
         borrow_reg   <= 1'b0;
         overflow_reg <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (i_valid) begin
                  a_reg        <= i_minuend;
                  b_inv_reg    <= ~i_subtrahend;
                  a_msb_reg    <= i_minuend[WIDTH-1];
                  b_msb_reg    <= i_subtrahend[WIDTH-1];
                  carry_reg    <= 1'b1;
                  k_reg        <= '0;
                  skip_reg     <= '0;
                  borrow_reg   <= 1'b0;
                  overflow_reg <= 1'b0;
               end
            end
            RUN: begin
               result_reg[k_reg*BLOCK +: BLOCK] <= slice_sum;
               carry_reg <= slice_cout;
               skip_reg  <= skip_reg + CW'(slice_p);
               k_reg     <= k_reg + KW'(1);
               // Flags are settled on the final slice so DONE only presents registers.
               if (last_slice) begin
                  borrow_reg   <= ~slice_cout;
                  overflow_reg <= (a_msb_reg ^ b_msb_reg) & (slice_sum[BLOCK-1] ^ a_msb_reg);
               end
            end
            default: ;
         endcase
      end
   end

   assign o_ready      = (state_reg == IDLE);
   assign o_valid      = (state_reg == DONE);
   assign o_result     = result_reg;
   assign o_borrow     = borrow_reg;
   assign o_overflow   = overflow_reg;
   assign o_skip_count = skip_reg;

endmodule

// File: tb/tb_cskip_sub_serial.sv
// Self-checking bench for cskip_sub_serial (WIDTH=16, BLOCK=4): expected results
// are queued at accept and compared when the result handshake completes.
module tb_cskip_sub_serial;

   logic        i_clk = 1'b0;
   logic        i_rst;
   logic        i_valid;
   logic        o_ready;
   logic [15:0] i_minuend;
   logic [15:0] i_subtrahend;
   logic        o_valid;
   logic        i_ready;
   logic [15:0] o_result;
   logic        o_borrow;
   logic        o_overflow;
   logic [2:0]  o_skip_count;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [15:0] result;
      logic        borrow;
      logic        overflow;
      logic [2:0]  skip;
   } exp_t;

   exp_t sb[$];

   cskip_sub_serial #(
      .WIDTH (16),
      .BLOCK (4)
   ) dut (
      .i_clk        (i_clk),
      .i_rst        (i_rst),
      .i_valid      (i_valid),
      .o_ready      (o_ready),
      .i_minuend    (i_minuend),
      .i_subtrahend (i_subtrahend),
      .o_valid      (o_valid),
      .i_ready      (i_ready),
      .o_result     (o_result),
      .o_borrow     (o_borrow),
      .o_overflow   (o_overflow),
      .o_skip_count (o_skip_count)
   );

   always #5 i_clk = ~i_clk;

   function automatic exp_t model(input logic [15:0] a, input logic [15:0] b);
      exp_t        e;
      logic [15:0] nb;
      nb         = ~b;
      e.result   = a - b;
      e.borrow   = (a < b);
      e.overflow = (a[15] != b[15]) && (e.result[15] != a[15]);
      e.skip     = 3'd0;
      for (int s = 0; s < 4; s++) begin
         if (&(a[s*4 +: 4] ^ nb[s*4 +: 4])) e.skip = e.skip + 3'd1;
      end
      return e;
   endfunction

   function automatic exp_t mk(input logic [15:0] r, input logic bw, input logic ov, input logic [2:0] sk);
      exp_t e;
      e.result = r; e.borrow = bw; e.overflow = ov; e.skip = sk;
      return e;
   endfunction

   task automatic step();
      @(posedge i_clk);
      #1;
   endtask

   // Waits for o_ready, then presents one operation for a single accept edge.
   task automatic start_op(input logic [15:0] a, input logic [15:0] b, input exp_t e, input bit push);
      int n;
      n = 0;
      while (!o_ready && n < 20) begin
         step();
         n++;
      end
      checks++;
      if (!o_ready) begin
         errors++;
         $display("FAIL ready_timeout o_ready got %b want 1", o_ready);
      end
      i_minuend    = a;
      i_subtrahend = b;
      i_valid      = 1'b1;
      step();
      i_valid = 1'b0;
      if (push) sb.push_back(e);
      $display("accept a=%h b=%h", a, b);
   endtask

   task automatic finish_op(input string tag);
      int   lat;
      exp_t e;
      lat = 0;
      while (!o_valid && lat < 20) begin
         step();
         lat++;
      end
      checks++;
      if (!o_valid || lat != 4) begin
         errors++;
         $display("FAIL %s latency got %0d (valid=%b) want 4", tag, lat, o_valid);
      end
      if (!o_valid) return;
      checks++;
      if (sb.size() == 0) begin
         errors++;
         $display("FAIL %s scoreboard got result %h with empty queue", tag, o_result);
         return;
      end
      e = sb.pop_front();
      if (o_result !== e.result || o_borrow !== e.borrow ||
          o_overflow !== e.overflow || o_skip_count !== e.skip) begin
         errors++;
         $display("FAIL %s result got %h/b%b/o%b/s%0d want %h/b%b/o%b/s%0d", tag,
                  o_result, o_borrow, o_overflow, o_skip_count,
                  e.result, e.borrow, e.overflow, e.skip);
      end else begin
         $display("result %s %h borrow=%b overflow=%b skip=%0d", tag,
                  o_result, o_borrow, o_overflow, o_skip_count);
      end
      if (i_ready) begin
         step();
         checks++;
         if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s release got valid=%b ready=%b want 0/1", tag, o_valid, o_ready);
         end
      end
   endtask

   task automatic check_reset_values(input string tag);
      checks++;
      if (o_valid !== 1'b0 || o_ready !== 1'b1 || o_result !== 16'h0000 ||
          o_borrow !== 1'b0 || o_overflow !== 1'b0 || o_skip_count !== 3'd0) begin
         errors++;
         $display("FAIL %s reset_values got v%b r%b %h b%b o%b s%0d want v0 r1 0000 b0 o0 s0", tag,
                  o_valid, o_ready, o_result, o_borrow, o_overflow, o_skip_count);
      end
   endtask

   task automatic expect_no_valid(input int cycles, input string tag);
      bit seen;
      seen = 1'b0;
      for (int c = 0; c < cycles; c++) begin
         step();
         if (o_valid) seen = 1'b1;
      end
      checks++;
      if (seen) begin
         errors++;
         $display("FAIL %s spurious o_valid got 1 want 0", tag);
      end
   endtask

   task automatic test_reset();
      i_rst = 1'b1;
      step();
      step();
      i_rst = 1'b0;
      check_reset_values("reset");
   endtask

   task automatic test_plan_vectors();
      start_op(16'h1234, 16'h0034, mk(16'h1200, 1'b0, 1'b0, 3'd2), 1'b1);
      finish_op("sub_1234_0034");
      start_op(16'h0000, 16'h0001, mk(16'hFFFF, 1'b1, 1'b0, 3'd3), 1'b1);
      finish_op("sub_0000_0001");
      start_op(16'h8000, 16'h0001, mk(16'h7FFF, 1'b0, 1'b1, 3'd2), 1'b1);
      finish_op("sub_8000_0001");
      start_op(16'h5555, 16'h5555, mk(16'h0000, 1'b0, 1'b0, 3'd4), 1'b1);
      finish_op("sub_full_skip");
   endtask

   task automatic test_backpressure();
      logic [15:0] held_result;
      logic [2:0]  held_skip;
      logic        held_borrow, held_overflow;
      i_ready = 1'b0;
      start_op(16'h0F00, 16'h1001, model(16'h0F00, 16'h1001), 1'b1);
      finish_op("bp_first");
      held_result   = o_result;
      held_skip     = o_skip_count;
      held_borrow   = o_borrow;
      held_overflow = o_overflow;
      for (int c = 0; c < 3; c++) begin
         i_minuend    = 16'hAAAA;
         i_subtrahend = 16'h1111;
         i_valid      = 1'b1;
         step();
         checks++;
         if (o_valid !== 1'b1 || o_ready !== 1'b0 || o_result !== held_result ||
             o_skip_count !== held_skip || o_borrow !== held_borrow || o_overflow !== held_overflow) begin
            errors++;
            $display("FAIL bp_hold cycle %0d got v%b r%b %h want v1 r0 %h", c,
                     o_valid, o_ready, o_result, held_result);
         end
      end
      i_valid = 1'b0;
      i_ready = 1'b1;
      step();
      checks++;
      if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
         errors++;
         $display("FAIL bp_release got valid=%b ready=%b want 0/1", o_valid, o_ready);
      end
      start_op(16'h00FF, 16'h0100, model(16'h00FF, 16'h0100), 1'b1);
      finish_op("bp_next");
   endtask

   task automatic test_back_to_back();
      logic [15:0] a, b;
      for (int n = 0; n < 6; n++) begin
         a = 16'($urandom);
         b = 16'($urandom);
         start_op(a, b, model(a, b), 1'b1);
         finish_op("b2b_random");
      end
   endtask

   task automatic test_reset_mid_run();
      start_op(16'h1234, 16'h0034, mk(16'h0, 1'b0, 1'b0, 3'd0), 1'b0);
      step();
      i_rst = 1'b1;
      step();
      i_rst = 1'b0;
      check_reset_values("mid_run_reset");
      expect_no_valid(10, "mid_run_abort");
      start_op(16'h0003, 16'h0001, mk(16'h0002, 1'b0, 1'b0, 3'd3), 1'b1);
      finish_op("after_abort");
   endtask

   task automatic test_reset_on_accept();
      i_minuend    = 16'h4444;
      i_subtrahend = 16'h2222;
      i_valid      = 1'b1;
      i_rst        = 1'b1;
      step();
      i_valid = 1'b0;
      i_rst   = 1'b0;
      check_reset_values("reset_on_accept");
      expect_no_valid(8, "reset_on_accept_capture");
   endtask

   initial begin
      i_rst        = 1'b1;
      i_valid      = 1'b0;
      i_ready      = 1'b1;
      i_minuend    = 16'h0000;
      i_subtrahend = 16'h0000;
      test_reset();
      test_plan_vectors();
      test_backpressure();
      test_back_to_back();
      test_reset_mid_run();
      test_reset_on_accept();
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain got %0d pending want 0", sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
